// File: rtl/cellrv32_package.sv
// Shared types and helpers for the CELLRV32 co-processor sequencer.
// Sequencer states, the main control bus view and a one-hot test.
package cellrv32_package;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    COLLECT = 2'd2
  } cp_seq_state_t;

  // Only the trap flag of the main control bus is of interest to the sequencer.
  typedef struct packed {
    logic cpu_trap;
  } ctrl_bus_t;

  function automatic logic onehot_f(input logic [31:0] vec);
    return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/cellrv32_cpu_cp_sequencer.sv
// Co-processor sequencer: starts one selected co-processor, waits for its valid,
// returns its result with a done pulse, or aborts on trap / timeout / bad select.
module cellrv32_cpu_cp_sequencer
  import cellrv32_package::*;
#(
  parameter int XLEN    = 32,
  parameter int NCP     = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  ctrl_bus_t           ctrl_i,
  input  logic                issue_i,
  input  logic [NCP-1:0]      sel_i,
  output logic [NCP-1:0]      cp_start_o,
  input  logic [NCP-1:0]      cp_valid_i,
  input  logic [NCP*XLEN-1:0] cp_res_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [XLEN-1:0]     res_o,
  output logic                err_o
);

  localparam int              CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  cp_seq_state_t   state_q, state_d;
  logic [NCP-1:0]  sel_q, sel_d;
  logic [NCP-1:0]  start_q, start_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0] res_mux;
  logic            trap;
  logic            hit;

  assign trap = ctrl_i.cpu_trap;
  assign hit  = |(cp_valid_i & sel_q);

  // sel_q is one-hot, so an AND-OR mux picks exactly one result slice.
  always_comb begin
    res_mux = '0;
    for (int i = 0; i < NCP; i++) begin
      res_mux = res_mux | (cp_res_i[i*XLEN +: XLEN] & {XLEN{sel_q[i]}});
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    start_d = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    res_d   = '0;
    case (state_q)
      IDLE: begin
        if (issue_i && !trap) begin
          if (onehot_f(32'(sel_i))) begin
            sel_d   = sel_i;
            cnt_d   = '0;
            start_d = sel_i;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      // Priority: trap aborts silently, then valid, then timeout.
      RUN: begin
        if (trap) begin
          state_d = IDLE;
        end else if (hit) begin
          state_d = COLLECT;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      COLLECT: begin
        state_d = IDLE;
        if (!trap) begin
          res_d  = res_mux;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      start_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      done_q  <= done_d;
      err_q   <= err_d;
      res_q   <= res_d;
    end
  end

  assign cp_start_o = start_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign res_o      = res_q;

endmodule

// File: doc/cellrv32_cpu_cp_sequencer.md
CELLRV32_CPU_CP_SEQUENCER -- requirements
Module: cellrv32_cpu_cp_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, data path width.
REQ-002 SHALL have parameter NCP, default 4, number of attached co-processors (shifter = index 0).
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum RUN cycles before abort (range 2..256).
REQ-004 SHALL have port clk_i  in  1  global clock, rising edge.
REQ-005 SHALL have port rstn_i  in  1  global reset, asynchronous, active-low.
REQ-006 SHALL have port ctrl_i  in  ctrl_bus_t  main control bus; only cpu_trap is used.
REQ-007 SHALL have port issue_i  in  1  request to start one co-processor operation.
REQ-008 SHALL have port sel_i  in  NCP  one-hot co-processor select, sampled with issue_i.
REQ-009 SHALL have port cp_start_o  out  NCP  per-co-processor start pulse.
REQ-010 SHALL have port cp_valid_i  in  NCP  per-co-processor valid_o.
REQ-011 SHALL have port cp_res_i  in  NCP*XLEN  concatenated co-processor results, index i at bits [i*XLEN +: XLEN].
REQ-012 SHALL have port busy_o  out  1  operation in flight.
REQ-013 SHALL have port done_o  out  1  single-cycle completion pulse.
REQ-014 SHALL have port res_o  out  XLEN  result, valid only while done_o=1, else zero.
REQ-015 SHALL have port err_o  out  1  single-cycle pulse on timeout or illegal select.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, COLLECT.
REQ-017 IDLE: issue_i=1, sel_i one-hot, cpu_trap=0 -> register sel_i into sel_q, clear timeout counter, go RUN.
REQ-018 IDLE: issue_i=1 with sel_i zero or multi-hot -> err_o=1 next cycle, stay IDLE, no start.
REQ-019 cp_start_o SHALL equal sel_q for exactly the first RUN cycle, zero otherwise (registered, never glitching).
REQ-020 RUN: (cp_valid_i & sel_q) != 0 -> go COLLECT; valid coinciding with the start cycle SHALL be accepted.
REQ-021 cp_valid_i bits not in sel_q SHALL be ignored.
REQ-022 COLLECT: res_o <= selected cp_res_i slice, done_o <= 1 at the next edge; state -> IDLE.
REQ-023 Latency with a co-processor valid in its start cycle: issue at cycle 0, start at cycle 1, done_o at cycle 3.
REQ-024 RUN counter SHALL increment per cycle; at TIMEOUT-1 without valid -> err_o pulse, IDLE, no done_o.
REQ-025 cpu_trap=1 in RUN or COLLECT SHALL return to IDLE next edge with no done_o and no err_o; trap outweighs valid and timeout in the same cycle.
REQ-026 cpu_trap=1 in IDLE SHALL suppress a simultaneous issue_i.
REQ-027 issue_i while busy_o=1 SHALL be ignored (no queueing).
REQ-028 busy_o SHALL be 1 in RUN and COLLECT and during the done_o cycle's preceding state only; 0 in IDLE.
REQ-029 A new issue SHALL be accepted in the same cycle done_o is high (back-to-back).
REQ-030 done_o and err_o SHALL never be high in the same cycle.

Reset
REQ-031 rstn_i=0 SHALL asynchronously force IDLE, sel_q=0, counter=0, cp_start_o=0, done_o=0, err_o=0, res_o=0; busy_o=0.
REQ-032 Reset mid-RUN SHALL drop cp_start_o immediately, with no completion reported after release.

Structure
REQ-033 State enum cp_seq_state_t and onehot_f(function) SHALL reside in cellrv32_package.
REQ-034 SHALL be a single module, no sub-modules; result selection an AND-OR mux over sel_q.

Verification
REQ-035 Barrel-like model (valid=start), issue sel=0001, res0=0x0000_00F0 -> start cycle 1, done_o cycle 3, res_o=0x0000_00F0.
REQ-036 Serial-like model valid 12 cycles after start, sel=0010, res1=0xDEAD_BEEF -> done_o once, res_o=0xDEAD_BEEF, busy_o high throughout.
REQ-037 sel_i=0011 with issue -> err_o pulse, cp_start_o stays 0000, busy_o stays 0.
REQ-038 TIMEOUT=8, no valid -> err_o at RUN cycle 8, no done_o, then new issue accepted.
REQ-039 cpu_trap in RUN cycle 3 with valid in same cycle -> IDLE, no done_o, no err_o.
REQ-040 rstn_i low mid-RUN then high, valid later asserted -> all outputs 0, no done_o.
